// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, answers after
// LATENCY cycles, and holds the response until the initiator takes it.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY   = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_accept;
   logic        w_enter_resp;
   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [3:0]  w_be;
   logic        w_err;
   logic [AW-1:0] w_idx;

   assign w_accept     = (r_state == S_IDLE) && req_valid;
   assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                         ((r_state == S_BUSY) && (r_cnt == 4'd1));

   // With LATENCY=1 the commit happens on the acceptance edge, so use the live request.
   assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
   assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
   assign w_be    = (r_state == S_IDLE) ? req_be    : r_be;

   assign w_err = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign w_idx = w_addr[AW+1:2];

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   // Array is deliberately outside the reset domain so contents survive rst.
   always_ff @(posedge clk) begin
      if (!rst && w_enter_resp && w_we && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_be    <= 4'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_be    <= req_be;
                  if (LATENCY == 1) begin
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_BUSY;
                     r_cnt   <= CNT_INIT;
                  end
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) r_state <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_enter_resp) begin
            r_err   <= w_err;
            r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model;
// a second LATENCY=1 instance covers back-to-back throughput.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid_b, req_ready_b, resp_valid_b, resp_err_b;
   logic [31:0] resp_rdata_b;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] mdl [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(1'b0),
      .req_addr(32'h13), .req_wdata(32'd0), .req_be(4'hF),
      .resp_valid(resp_valid_b), .resp_ready(1'b1),
      .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic addr_err(input logic [31:0] a);
      return (a % 4 != 0) || ((a / 4) >= DEPTH);
   endfunction

   // Model: the response a request should produce, plus the memory effect of a store.
   task automatic model_apply(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, output logic e, output logic [31:0] rd);
      e  = addr_err(a);
      rd = 32'd0;
      if (!e && we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mdl[a / 4][8*b +: 8] = wd[8*b +: 8];
      end else if (!e) begin
         rd = mdl[a / 4];
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
   task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int stall);
      int lat;
      logic e;
      logic [31:0] rd;
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
      resp_ready = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
         resp_ready = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, LAT);
      model_apply(we, a, wd, be, e, rd);
      chk("resp_err", {31'd0, resp_err}, {31'd0, e});
      chk("resp_rdata", resp_rdata, rd);
      resp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_ready", {31'd0, req_ready}, 32'd0);
         chk("stall_rdata", resp_rdata, rd);
         chk("stall_err", {31'd0, resp_err}, {31'd0, e});
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      resp_ready = 1'($urandom);
      chk("post_valid", {31'd0, resp_valid}, 32'd0);
      chk("post_req_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        e;
      logic [31:0] rd, a;
      int          acc, lat;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
      req_wdata = 32'd0; req_be = 4'd0; resp_ready = 1'b0; req_valid_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

      // Fill every word so the model has a known image.
      for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
      chk("store_load_0x10", mdl[4], 32'hDEADBEEF);
      txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
      txn(1'b1, 32'h14, 32'h12345678, 4'h0, 0);
      txn(1'b0, 32'h13, 32'h0, 4'hF, 1);
      txn(1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0);
      txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0, 0);
      txn(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 5);
      txn(1'b0, 32'h14, 32'h0, 4'h0, 0);

      // Reset during BUSY aborts a store.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("abort_valid", {31'd0, resp_valid}, 32'd0);
         chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
         @(negedge clk);
      end
      txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Reset during RESP drops the response but the store is already in memory.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h0BADF00D; req_be = 4'h6;
      resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
      chk("rst_resp_seen", {31'd0, resp_valid}, 32'd1);
      model_apply(1'b1, 32'h24, 32'h0BADF00D, 4'h6, e, rd);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_resp_drop", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("rst_resp_valid_after", {31'd0, resp_valid}, 32'd0);
      txn(1'b0, 32'h24, 32'h0, 4'h0, 0);

      // Random mix: mostly legal addresses, some misaligned or out of range.
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 3) * 4);
            2:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
         endcase
         txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
      end
      for (int i = 0; i < DEPTH; i++) txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0);

      // LATENCY=1 instance: held-high request with resp_ready tied high.
      req_valid_b = 1'b1;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         chk("l1_valid_vs_ready", {31'd0, resp_valid_b}, {31'd0, !req_ready_b});
         if (resp_valid_b) begin
            chk("l1_err", {31'd0, resp_err_b}, 32'd1);
            chk("l1_rdata", resp_rdata_b, 32'd0);
         end
         if (req_ready_b) acc++;
         @(negedge clk);
      end
      chk("l1_accept_count", acc, 10);
      req_valid_b = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL provide parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the memory array.
REQ-003 The block SHALL provide parameter LATENCY, default 2 (legal range 1..15), giving the cycles from request acceptance to response valid.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  byte enables; bit i selects wdata[8i+7:8i].
REQ-012 resp_valid  output  1  response is present.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load data; 0 for stores and for errors.
REQ-015 resp_err  output  1  misaligned or out-of-range access.

Function
REQ-016 The FSM SHALL have three states, IDLE, BUSY and RESP, with IDLE as the reset state.
REQ-017 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a clock edge where req_valid && req_ready.
REQ-018 On acceptance, we, addr, wdata and be SHALL be latched; later changes on the req_* inputs SHALL be ignored until the next acceptance.
REQ-019 On acceptance, the FSM SHALL move to BUSY and load a 4-bit down-counter with LATENCY-1; if LATENCY=1 it SHALL go directly to RESP.
REQ-020 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter is 1.
REQ-021 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-022 Only one transaction SHALL be outstanding at a time.
REQ-023 Error SHALL be flagged when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
REQ-024 On error, there SHALL be no memory write, resp_err=1 and resp_rdata=0.
REQ-025 A store SHALL be committed on the edge entering RESP, writing only the bytes whose be bit is 1.
REQ-026 A store with be=4'b0000 SHALL write nothing but still respond with err=0.
REQ-027 For a load, the full word SHALL be captured into resp_rdata on the edge entering RESP; be SHALL be ignored for loads.
REQ-028 In RESP, resp_valid SHALL be 1, and resp_rdata/resp_err SHALL be held stable until resp_ready=1.
REQ-029 On the edge where resp_valid && resp_ready, the FSM SHALL return to IDLE.
REQ-030 req_ready SHALL return to 1 in the following cycle, so there is a minimum of one idle cycle between responses.
REQ-031 resp_ready SHALL be ignored outside RESP.
REQ-032 req_valid SHALL be ignored outside IDLE.
REQ-033 resp_ready held low SHALL stall the block indefinitely without any state loss.
REQ-034 Addresses up to 32'hFFFF_FFFC SHALL produce no wrap-around into the array; the index SHALL be compared at full width.

Reset
REQ-035 While rst=1, on each edge the block SHALL set state=IDLE, counter=0, resp_valid=0, resp_err=0 and resp_rdata=0; req_ready=1 from the first cycle after reset is released.
REQ-036 rst SHALL have priority over all other inputs.
REQ-037 rst asserted in BUSY SHALL abort the transaction with no memory write.
REQ-038 rst asserted in RESP SHALL drop the pending response (the store has already been committed).
REQ-039 Memory array contents SHALL NOT be cleared by rst.

Verification
REQ-040 LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, be=0xF accepted at cycle t -> resp_valid=1 at t+2, err=0; a subsequent load of 0x10 returns 0xDEADBEEF.
REQ-041 Word 0x10 preloaded to 0xDEADBEEF, then store wdata=0x000000AA with be=0x1 -> a later load returns 0xDEADBEAA.
REQ-042 Load addr=0x13 -> resp_err=1, rdata=0; load addr=4*DEPTH_WORDS -> resp_err=1; memory is unchanged in both cases.
REQ-043 resp_ready held 0 for 5 cycles in RESP -> resp_valid, rdata and err stay constant and req_ready stays 0; resp_ready=1 -> IDLE, and req_ready=1 on the next cycle.
REQ-044 Store to 0x20 with rst pulsed during BUSY -> resp_valid never rises, word 0x20 retains its old value, and req_ready=1 after reset.
REQ-045 LATENCY=1: load accepted at t -> resp_valid=1 at t+1; with resp_ready tied to 1 and req_valid held high, requests are accepted every 2 cycles.
